// File: rtl/cache_bridge_pkg.sv
// ----------------------------------------------------------------------------
// cache_bridge_pkg
// Shared encodings for the cache-to-AXI bridge: cache read-type codes,
// read/write FSM state encodings, and AXI burst/size constants.
// Ports: none (package).
// ----------------------------------------------------------------------------
package cache_bridge_pkg;

    // Cache read request types
    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    // Read and write channel sequencers
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_B    = 2'd3
    } wstate_t;

    // AXI encodings
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_1     = 3'b000;
    localparam logic [2:0] AXI_SIZE_2     = 3'b001;
    localparam logic [2:0] AXI_SIZE_4     = 3'b010;

    function automatic logic is_line(input logic [2:0] rd_type);
        return (rd_type == RD_TYPE_LINE);
    endfunction

endpackage

// File: rtl/bridge_wbuf.sv
// ----------------------------------------------------------------------------
// bridge_wbuf
// Writeback line buffer: holds one dirty line and its address, and walks a
// beat counter to present one 32-bit word per accepted W beat.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   i_load           capture i_addr / i_line (write request accepted)
//   i_addr, i_line   line address and line data (word0 in [31:0])
//   i_clr            clear beat counter (entry to the data phase)
//   i_adv            advance beat counter (W beat accepted)
//   o_addr           buffered line address
//   o_wdata          word selected by the beat counter
//   o_wlast          high on the final beat of the line
// ----------------------------------------------------------------------------
module bridge_wbuf #(
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_load,
    input  logic [31:0]              i_addr,
    input  logic [LINE_WORDS*32-1:0] i_line,
    input  logic                     i_clr,
    input  logic                     i_adv,
    output logic [31:0]              o_addr,
    output logic [31:0]              o_wdata,
    output logic                     o_wlast
);

    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    logic [31:0]              r_addr;
    logic [LINE_WORDS*32-1:0] r_line;
    logic [CNT_W-1:0]         r_cnt;
    logic [31:0]              w_words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr <= '0;
            r_line <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_load) begin
                r_addr <= i_addr;
                r_line <= i_line;
            end
            // Clear has priority: it only fires on the AW handshake, when no
            // W beat can be in flight.
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_adv) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Split the line into words so the beat counter can index them directly
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
            assign w_words[gi] = r_line[gi*32 +: 32];
        end
    endgenerate

    assign o_addr  = r_addr;
    assign o_wdata = w_words[r_cnt];
    assign o_wlast = (r_cnt == LAST_BEAT);

endmodule

// File: rtl/cache_axi_bridge.sv
// ----------------------------------------------------------------------------
// cache_axi_bridge
// Responder for a cache refill/writeback interface, mastering AXI toward
// memory. One outstanding read and one outstanding write, each with its own
// sequencer. Line reads become LINE_WORDS-beat INCR bursts, uncached reads are
// single beats, writebacks are buffered and drained as one burst.
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   rd_req/rd_type/rd_addr/rd_rdy   cache read request channel
//   ret_valid/ret_last/ret_data     read return (direct passthrough of R)
//   wr_req/wr_addr/wr_data/wr_rdy   cache writeback channel
//   ar*/r*/aw*/w*/b*                AXI master channels
// Configuration:
//   CACHE_BRIDGE_RAW_BYPASS_EN  when defined, reads to a line other than the
//   one being written back may proceed while the writeback drains; otherwise
//   reads and writes are fully serialized.
// ----------------------------------------------------------------------------
module cache_axi_bridge
    import cache_bridge_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] RD_ID      = 4'd0,
    parameter logic [3:0] WR_ID      = 4'd1
) (
    input  logic                     clk,
    input  logic                     resetn,
    // cache read side
    input  logic                     rd_req,
    input  logic [2:0]               rd_type,
    input  logic [31:0]              rd_addr,
    output logic                     rd_rdy,
    output logic                     ret_valid,
    output logic [1:0]               ret_last,
    output logic [31:0]              ret_data,
    // cache write side
    input  logic                     wr_req,
    input  logic [31:0]              wr_addr,
    input  logic [LINE_WORDS*32-1:0] wr_data,
    output logic                     wr_rdy,
    // AXI AR
    output logic                     arvalid,
    input  logic                     arready,
    output logic [31:0]              araddr,
    output logic [3:0]               arid,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    // AXI R
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic [1:0]               rresp,
    input  logic [3:0]               rid,
    // AXI AW
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              awaddr,
    output logic [3:0]               awid,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    // AXI W
    output logic                     wvalid,
    input  logic                     wready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    // AXI B
    input  logic                     bvalid,
    output logic                     bready,
    input  logic [1:0]               bresp
);

    localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

    rstate_t     r_rstate;
    wstate_t     r_wstate;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic        r_rready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;

    logic        w_rd_rdy;
    logic        w_wr_rdy;
    logic        w_rd_accept;
    logic        w_wr_accept;
    logic        w_aw_hs;
    logic [31:0] w_wbuf_addr;
    logic [31:0] w_wbuf_wdata;
    logic        w_wbuf_wlast;

    // Responses and IDs are not acted upon by this bridge.
    logic        w_unused_ok;
    assign w_unused_ok = &{1'b0, rresp, rid, bresp};

    // ------------------------------------------------------------------
    // Accept logic
    // ------------------------------------------------------------------
    assign w_wr_rdy = (r_wstate == W_IDLE);

`ifdef CACHE_BRIDGE_RAW_BYPASS_EN
    // Only a read that hits the line being (or about to be) written back
    // must wait; everything else may overlap with the writeback.
    logic w_line_conflict;
    assign w_line_conflict =
        ((r_wstate != W_IDLE) && (rd_addr[31:4] == w_wbuf_addr[31:4])) ||
        (wr_req && (rd_addr[31:4] == wr_addr[31:4]));
    assign w_rd_rdy = (r_rstate == R_IDLE) && !w_line_conflict;
`else
    // Reads wait for any writeback, including one being requested right
    // now, so memory never returns stale data for a just-evicted line.
    assign w_rd_rdy = (r_rstate == R_IDLE) && (r_wstate == W_IDLE) && !wr_req;
`endif

    assign w_rd_accept = rd_req && w_rd_rdy;
    assign w_wr_accept = wr_req && w_wr_rdy;
    assign w_aw_hs     = r_awvalid && awready;

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_rready  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_rd_accept) begin
                        r_rstate  <= R_AR;
                        r_arvalid <= 1'b1;
                        r_araddr  <= rd_addr;
                        if (is_line(rd_type)) begin
                            r_arlen  <= BURST_LEN;
                            r_arsize <= AXI_SIZE_4;
                        end else begin
                            r_arlen  <= 8'd0;
                            r_arsize <= {1'b0, rd_type[1:0]};
                        end
                    end
                end
                R_AR: begin
                    if (r_arvalid && arready) begin
                        r_rstate  <= R_DATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        r_rstate <= R_IDLE;
                        r_rready <= 1'b0;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_accept) begin
                        r_wstate  <= W_AW;
                        r_awvalid <= 1'b1;
                    end
                end
                W_AW: begin
                    // W is held off until the address has been taken
                    if (w_aw_hs) begin
                        r_wstate  <= W_DATA;
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wready && w_wbuf_wlast) begin
                        r_wstate <= W_B;
                        r_wvalid <= 1'b0;
                        r_bready <= 1'b1;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        r_wstate <= W_IDLE;
                        r_bready <= 1'b0;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                end
            endcase
        end
    end

    bridge_wbuf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_wbuf (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_wr_accept),
        .i_addr  (wr_addr),
        .i_line  (wr_data),
        .i_clr   (w_aw_hs),
        .i_adv   (r_wvalid && wready),
        .o_addr  (w_wbuf_addr),
        .o_wdata (w_wbuf_wdata),
        .o_wlast (w_wbuf_wlast)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_rdy    = w_rd_rdy;
    assign wr_rdy    = w_wr_rdy;

    assign arvalid   = r_arvalid;
    assign araddr    = r_araddr;
    assign arid      = RD_ID;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign arburst   = AXI_BURST_INCR;

    // R is passed straight through; rready doubles as "in data phase"
    assign rready    = r_rready;
    assign ret_valid = r_rready && rvalid;
    assign ret_data  = rdata;
    assign ret_last  = {1'b0, r_rready && rlast};

    assign awvalid   = r_awvalid;
    assign awaddr    = w_wbuf_addr;
    assign awid      = WR_ID;
    assign awlen     = BURST_LEN;
    assign awsize    = AXI_SIZE_4;
    assign awburst   = AXI_BURST_INCR;

    assign wvalid    = r_wvalid;
    assign wdata     = w_wbuf_wdata;
    assign wstrb     = 4'hf;
    assign wlast     = r_wvalid && w_wbuf_wlast;

    assign bready    = r_bready;

endmodule
